// File: rtl/seg14_scroll_driver_if.sv
// Host-side bus of the 14-segment scroll driver: message buffer writes and display mode controls.
interface seg14_scroll_driver_if #(
    parameter int unsigned MSG_DEPTH = 32
) ();
    localparam int unsigned AW = $clog2(MSG_DEPTH);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [5:0]    wr_char;
    logic [AW:0]   msg_len;
    logic          scroll_en;
    logic          blank;

    modport master (output wr_en, wr_addr, wr_char, msg_len, scroll_en, blank);
    modport slave  (input  wr_en, wr_addr, wr_char, msg_len, scroll_en, blank);
endinterface

// File: rtl/seg14_scroll_driver.sv
// Time-multiplexed 14-segment digit driver with a writable message buffer and optional
// wrap-around scrolling. Segment order, MSB first: a b c d e f g1 g2 h i j k l m.
module seg14_scroll_driver #(
    parameter int unsigned N_DIGITS      = 12,
    parameter int unsigned MSG_DEPTH     = 32,
    parameter int unsigned PRESCALE      = 1,
    parameter int unsigned SCROLL_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seg14_scroll_driver_if.slave    bus,
    output logic [N_DIGITS-1:0]     sel_o,
    output logic [13:0]             segm_o,
    output logic                    frame_done_o
);
    localparam int unsigned AW = $clog2(MSG_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned DW = $clog2(N_DIGITS);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [PW-1:0] PcLast  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DigLast = DW'(N_DIGITS - 1);
    localparam logic [FW-1:0] FcLast  = FW'(SCROLL_FRAMES - 1);

    function automatic logic [13:0] glyph(input logic [5:0] code);
        logic [13:0] g;
        case (code)
            6'd1:    g = 14'b1110_1111_000000;  // A
            6'd2:    g = 14'b1111_0001_010010;
            6'd3:    g = 14'b1001_1100_000000;
            6'd4:    g = 14'b1111_0000_010010;
            6'd5:    g = 14'b1001_1110_000000;
            6'd6:    g = 14'b1000_1110_000000;
            6'd7:    g = 14'b1011_1101_000000;
            6'd8:    g = 14'b0110_1111_000000;
            6'd9:    g = 14'b1001_0000_010010;
            6'd10:   g = 14'b0111_1000_000000;
            6'd11:   g = 14'b0000_1110_001100;
            6'd12:   g = 14'b0001_1100_000000;
            6'd13:   g = 14'b0110_1100_101000;
            6'd14:   g = 14'b0110_1100_100100;
            6'd15:   g = 14'b1111_1100_000000;
            6'd16:   g = 14'b1100_1111_000000;
            6'd17:   g = 14'b1111_1100_000100;
            6'd18:   g = 14'b1100_1111_000100;
            6'd19:   g = 14'b1011_0111_000000;
            6'd20:   g = 14'b1000_0000_010010;
            6'd21:   g = 14'b0111_1100_000000;
            6'd22:   g = 14'b0000_1100_001001;
            6'd23:   g = 14'b0110_1100_000101;
            6'd24:   g = 14'b0000_0000_101101;
            6'd25:   g = 14'b0000_0000_101010;
            6'd26:   g = 14'b1001_0000_001001;  // Z
            6'd27:   g = 14'b1111_1100_001001;  // '0'
            6'd28:   g = 14'b0110_0000_001000;
            6'd29:   g = 14'b1101_1011_000000;
            6'd30:   g = 14'b1111_0001_000000;
            6'd31:   g = 14'b0110_0111_000000;
            6'd32:   g = 14'b1011_0111_000000;
            6'd33:   g = 14'b1011_1111_000000;
            6'd34:   g = 14'b1110_0000_000000;
            6'd35:   g = 14'b1111_1111_000000;
            6'd36:   g = 14'b1111_0111_000000;  // '9'
            default: g = 14'b0;
        endcase
        return g;
    endfunction

    logic [5:0]          msg_q [MSG_DEPTH];
    logic [PW-1:0]       pc_q, pc_d;
    logic [DW-1:0]       dig_q, dig_d;
    logic [AW-1:0]       cidx_q, cidx_d;
    logic [AW-1:0]       offset_q, offset_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;
    logic                wrap_q;
    logic [N_DIGITS-1:0] sel_q, sel_d;
    logic [13:0]         segm_q, segm_d;
    logic                frame_done_q;

    logic [LW-1:0] len;
    logic          adv, wrap, step;
    logic [5:0]    code;

    always_comb begin
        len  = (bus.msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : bus.msg_len;
        adv  = (pc_q == PcLast);
        wrap = adv && (dig_q == DigLast);
        step = 1'b0;

        pc_d  = adv ? '0 : pc_q + PW'(1);
        dig_d = dig_q;
        if (adv) begin
            dig_d = (dig_q == DigLast) ? '0 : dig_q + DW'(1);
        end

        fcnt_d = fcnt_q;
        if (!bus.scroll_en) begin
            fcnt_d = '0;
        end else if (wrap) begin
            if (fcnt_q == FcLast) begin
                fcnt_d = '0;
                step   = 1'b1;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        // Out-of-range offset (e.g. after msg_len shrinks) beats a pending scroll step.
        offset_d = offset_q;
        if (!bus.scroll_en || (len == '0) || ({1'b0, offset_q} >= len)) begin
            offset_d = '0;
        end else if (step) begin
            offset_d = (({1'b0, offset_q} + LW'(1)) == len) ? '0 : offset_q + AW'(1);
        end

        // Frame start loads the post-step offset so a scroll step never lands mid-frame.
        cidx_d = cidx_q;
        if (len == '0) begin
            cidx_d = '0;
        end else if (wrap) begin
            cidx_d = offset_d;
        end else if ({1'b0, cidx_q} >= len) begin
            cidx_d = '0;
        end else if (adv) begin
            cidx_d = (({1'b0, cidx_q} + LW'(1)) == len) ? '0 : cidx_q + AW'(1);
        end

        if ((len == '0) || (!bus.scroll_en && (32'(dig_q) >= 32'(len)))) begin
            code = 6'd0;
        end else begin
            code = msg_q[cidx_q];
        end

        sel_d  = bus.blank ? '0 : (N_DIGITS'(1) << dig_q);
        segm_d = bus.blank ? '0 : glyph(code);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MSG_DEPTH; i++) begin
                msg_q[AW'(i)] <= '0;
            end
        end else if (bus.wr_en) begin
            msg_q[bus.wr_addr] <= bus.wr_char;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            dig_q        <= '0;
            cidx_q       <= '0;
            offset_q     <= '0;
            fcnt_q       <= '0;
            wrap_q       <= 1'b0;
            sel_q        <= '0;
            segm_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            dig_q        <= dig_d;
            cidx_q       <= cidx_d;
            offset_q     <= offset_d;
            fcnt_q       <= fcnt_d;
            wrap_q       <= wrap;
            sel_q        <= sel_d;
            segm_q       <= segm_d;
            frame_done_q <= wrap_q;
        end
    end

    assign sel_o        = sel_q;
    assign segm_o       = segm_q;
    assign frame_done_o = frame_done_q;
endmodule

// File: tb/tb_seg14_scroll_driver.sv
// Bench for seg14_scroll_driver: cycle-level reference model plus directed literal checks.
module tb_seg14_scroll_driver;
    localparam int unsigned ND = 12;
    localparam int unsigned MD = 32;
    localparam int unsigned SF = 2;
    localparam int unsigned FR = ND;      // frame length of the PRESCALE=1 instance
    localparam int unsigned FR3 = ND * 3;

    localparam logic [13:0] G_I = 14'b10010000010010;
    localparam logic [13:0] G_R = 14'b11001111000100;
    localparam logic [13:0] G_A = 14'b11101111000000;
    localparam logic [13:0] G_M = 14'b01101100101000;
    localparam logic [13:0] G_0 = 14'b11111100001001;
    localparam logic [13:0] G_1 = 14'b01100000001000;

    localparam logic [13:0] FONT [37] = '{
        14'b00000000000000, 14'b11101111000000, 14'b11110001010010, 14'b10011100000000,
        14'b11110000010010, 14'b10011110000000, 14'b10001110000000, 14'b10111101000000,
        14'b01101111000000, 14'b10010000010010, 14'b01111000000000, 14'b00001110001100,
        14'b00011100000000, 14'b01101100101000, 14'b01101100100100, 14'b11111100000000,
        14'b11001111000000, 14'b11111100000100, 14'b11001111000100, 14'b10110111000000,
        14'b10000000010010, 14'b01111100000000, 14'b00001100001001, 14'b01101100000101,
        14'b00000000101101, 14'b00000000101010, 14'b10010000001001, 14'b11111100001001,
        14'b01100000001000, 14'b11011011000000, 14'b11110001000000, 14'b01100111000000,
        14'b10110111000000, 14'b10111111000000, 14'b11100000000000, 14'b11111111000000,
        14'b11110111000000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg14_scroll_driver_if #(.MSG_DEPTH(MD)) bus ();

    logic [ND-1:0] sel, sel3;
    logic [13:0]   segm, segm3;
    logic          fd, fd3;

    seg14_scroll_driver #(.N_DIGITS(ND), .MSG_DEPTH(MD), .PRESCALE(1), .SCROLL_FRAMES(SF)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .sel_o(sel), .segm_o(segm), .frame_done_o(fd));

    seg14_scroll_driver #(.N_DIGITS(ND), .MSG_DEPTH(MD), .PRESCALE(3), .SCROLL_FRAMES(SF)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus), .sel_o(sel3), .segm_o(segm3), .frame_done_o(fd3));

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] font(input logic [5:0] c);
        return (c < 6'd37) ? FONT[int'(c)] : 14'b0;
    endfunction

    // Reference model: outputs for the edge are derived from the cycle count since reset.
    int unsigned t;
    int m_off, m_fcnt, m_foff, f_len, m_len, m_dig;
    bit f_scr, dirty, m_scr, m_wrap, m_step;
    logic [5:0] m_buf [MD];
    logic [5:0] m_code;
    logic [ND-1:0] e_sel, e_sel3;
    logic [13:0] e_segm;
    logic e_fd, e_fd3, e_chk;

    task automatic model_reset();
        t = 0; m_off = 0; m_fcnt = 0; m_foff = 0; dirty = 0; f_len = 0; f_scr = 0;
        for (int i = 0; i < MD; i++) m_buf[i] = 6'd0;
        e_sel = '0; e_sel3 = '0; e_segm = '0; e_fd = 0; e_fd3 = 0; e_chk = 1;
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_len = (int'(bus.msg_len) > MD) ? MD : int'(bus.msg_len);
                m_scr = bus.scroll_en;
                if (t == 0) begin f_len = m_len; f_scr = m_scr; end
                if (m_len != f_len || m_scr != f_scr) dirty = 1;
                m_dig = int'(t % ND);
                if (m_len == 0) m_code = 6'd0;
                else if (m_scr) m_code = m_buf[(m_foff + m_dig) % m_len];
                else m_code = (m_dig < m_len) ? m_buf[m_dig] : 6'd0;
                e_sel  = bus.blank ? '0 : (ND'(1) << m_dig);
                e_segm = bus.blank ? '0 : font(m_code);
                e_chk  = bus.blank || !dirty;
                e_fd   = (t % FR == 0) && (t > 0);
                e_sel3 = bus.blank ? '0 : (ND'(1) << ((t / 3) % ND));
                e_fd3  = (t % FR3 == 0) && (t > 0);
                m_wrap = (t % FR == FR - 1);
                m_step = 0;
                if (!m_scr) m_fcnt = 0;
                else if (m_wrap) begin
                    m_fcnt++;
                    if (m_fcnt == SF) begin m_fcnt = 0; m_step = 1; end
                end
                if (!m_scr || m_len == 0 || m_off >= m_len) m_off = 0;
                else if (m_step) m_off = (m_off + 1) % m_len;
                if (m_wrap) begin m_foff = m_off; f_len = m_len; f_scr = m_scr; dirty = 0; end
                if (bus.wr_en) m_buf[bus.wr_addr] = bus.wr_char;
                t++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd(input string nm);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (fd !== 1'b1 && n < 100);
        chk(nm, 32'(fd), 1);
    endtask

    function automatic logic [13:0] word_glyph(input int o);
        case (o)
            0: return G_I;
            1: return G_R;
            2, 3: return G_A;
            default: return G_M;
        endcase
    endfunction

    initial begin : stim
        int n, d;
        logic [ND-1:0] s0;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_char = '0;
        bus.msg_len = '0; bus.scroll_en = 0; bus.blank = 0;

        fork
            forever begin
                @(negedge clk);
                chk("sel", 32'(sel), 32'(e_sel));
                if (e_chk) chk("segm", 32'(segm), 32'(e_segm));
                chk("frame_done", 32'(fd), 32'(e_fd));
                chk("sel_p3", 32'(sel3), 32'(e_sel3));
                chk("frame_done_p3", 32'(fd3), 32'(e_fd3));
            end
        join_none

        tick(3);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_segm", 32'(segm), 0);
        chk("rst_fd", 32'(fd), 0);
        rst_n = 1;
        tick(1);
        chk("first_sel", 32'(sel), 1);

        // Load I R A A M, static mode.
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1; bus.wr_addr = 5'(i);
            bus.wr_char = (i == 0) ? 6'd9 : (i == 1) ? 6'd18 : (i == 4) ? 6'd13 : 6'd1;
            tick(1);
        end
        bus.wr_en = 0;
        bus.msg_len = 6'd5;
        tick(1);
        wait_fd("static_fd");
        for (int k = 0; k < 12; k++) begin
            chk("static_sel", 32'(sel), 32'(ND'(1) << k));
            chk("static_segm", 32'(segm), (k < 5) ? 32'(word_glyph(k)) : 0);
            chk("static_fd_pos", 32'(fd), (k == 0) ? 1 : 0);
            tick(1);
        end
        chk("fd_period_12", 32'(fd), 1);

        // Scroll with SCROLL_FRAMES=2: digit 0 shows offset (frame/2) mod 5.
        bus.scroll_en = 1;
        for (int j = 1; j <= 10; j++) begin
            wait_fd("scroll_fd");
            chk("scroll_dig0", 32'(segm), 32'(word_glyph((j / 2) % 5)));
            if (j == 1) begin
                tick(5);
                chk("scroll_rep_sel", 32'(sel), 32'(ND'(1) << 5));
                chk("scroll_rep_dig5", 32'(segm), 32'(G_I));
            end
        end
        for (int j = 0; j < 8; j++) wait_fd("scroll_fd2");
        chk("scroll_off4", 32'(segm), 32'(G_M));
        tick(2);
        bus.msg_len = 6'd2;
        wait_fd("shrink_fd");
        for (int k = 0; k < 12; k++) begin
            chk("shrink_segm", 32'(segm), (k % 2 == 0) ? 32'(G_I) : 32'(G_R));
            tick(1);
        end
        bus.msg_len = 6'd0;
        wait_fd("len0_fd");
        for (int k = 0; k < 12; k++) begin
            chk("len0_segm", 32'(segm), 0);
            tick(1);
        end

        // PRESCALE=3 instance: each digit held 3 clocks, frame 36 clocks.
        bus.msg_len = 6'd5; bus.scroll_en = 0;
        n = 0;
        do begin tick(1); n++; end while (fd3 !== 1'b1 && n < 200);
        chk("p3_fd_seen", 32'(fd3), 1);
        for (int k = 0; k < 36; k++) begin
            chk("p3_sel_hold", 32'(sel3), 32'(ND'(1) << (k / 3)));
            chk("p3_fd_pos", 32'(fd3), (k == 0) ? 1 : 0);
            tick(1);
        end
        chk("p3_fd_period", 32'(fd3), 1);

        // Blank for 5 clocks mid-frame; counters keep running.
        wait_fd("blank_fd");
        tick(3);
        s0 = sel;
        d = 0;
        for (int b = 0; b < ND; b++) if (s0[b]) d = b;
        bus.blank = 1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("blank_sel", 32'(sel), 0);
            chk("blank_segm", 32'(segm), 0);
        end
        bus.blank = 0;
        tick(1);
        chk("unblank_phase", 32'(sel), 32'(ND'(1) << ((d + 6) % ND)));

        // Asynchronous reset mid-frame in scroll mode.
        bus.scroll_en = 1;
        tick(7);
        #2 rst_n = 0;
        #1;
        chk("async_rst_sel", 32'(sel), 0);
        chk("async_rst_segm", 32'(segm), 0);
        chk("async_rst_fd", 32'(fd), 0);
        chk("async_rst_sel3", 32'(sel3), 0);
        tick(2);
        rst_n = 1;
        tick(1);
        chk("restart_sel", 32'(sel), 1);
        wait_fd("rst_fd");
        for (int k = 0; k < 12; k++) begin
            chk("rst_buf_space", 32'(segm), 0);
            tick(1);
        end

        // Digit glyphs '0' and '1'.
        bus.scroll_en = 0; bus.msg_len = 6'd2;
        bus.wr_en = 1; bus.wr_addr = 5'd0; bus.wr_char = 6'd27;
        tick(1);
        bus.wr_addr = 5'd1; bus.wr_char = 6'd28;
        tick(1);
        bus.wr_en = 0;
        wait_fd("digit_fd");
        chk("glyph_0", 32'(segm), 32'(G_0));
        tick(1);
        chk("glyph_1", 32'(segm), 32'(G_1));

        // Randomized traffic checked by the model.
        bus.msg_len = 6'd7; bus.scroll_en = 1;
        for (int c = 0; c < 4000; c++) begin
            tick(1);
            bus.wr_en = ($urandom % 4 == 0);
            bus.wr_addr = 5'($urandom);
            bus.wr_char = ($urandom % 2 == 0) ? 6'($urandom_range(0, 36)) : 6'($urandom);
            if ($urandom % 200 == 0) bus.msg_len = 6'($urandom_range(0, 40));
            if ($urandom % 1000 == 0) bus.msg_len = 6'($urandom_range(33, 63));
            if ($urandom % 300 == 0) bus.scroll_en = ~bus.scroll_en;
            bus.blank = ($urandom % 8 == 0);
        end
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
